// File: rtl/bus_sequencer_if.sv
// Handshake and bus-control signal bundle between the bus sequencer and its datapath.
interface bus_sequencer_if #(
    parameter int unsigned DATA_W = 24
);
    logic              start;
    logic [DATA_W-1:0] ir_in;
    logic              alu_z;
    logic              dmem_ack;
    logic [15:0]       bus_rd_en;
    logic [15:0]       bus_wr_en;
    logic [2:0]        alu_op;
    logic              ir_write;
    logic              pc_inc;
    logic              ac_reset;
    logic              dmem_req;
    logic              dmem_we;
    logic              busy;
    logic              halted;
    logic [1:0]        err;

    modport master (
        input  start, ir_in, alu_z, dmem_ack,
        output bus_rd_en, bus_wr_en, alu_op, ir_write, pc_inc, ac_reset,
               dmem_req, dmem_we, busy, halted, err
    );

    modport slave (
        output start, ir_in, alu_z, dmem_ack,
        input  bus_rd_en, bus_wr_en, alu_op, ir_write, pc_inc, ac_reset,
               dmem_req, dmem_we, busy, halted, err
    );
endinterface

// File: rtl/bus_sequencer.sv
// Control FSM for the shared B-bus/C-bus datapath: fetch, decode, one-hot bus enables,
// ALU op select and the DMEM request handshake with timeout.
module bus_sequencer #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    bus_sequencer_if.master bus
);
    localparam int unsigned TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_MEM_WAIT = 3'd4;
    localparam logic [2:0] S_MEM_CAP  = 3'd5;
    localparam logic [2:0] S_HALT     = 3'd6;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_LOAD  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_INC   = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;
    localparam logic [3:0] OP_CLRAC = 4'd9;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [3:0] R_NONE = 4'd0;
    localparam logic [3:0] R_AC   = 4'd10;
    localparam logic [3:0] R_PC   = 4'd11;
    localparam logic [3:0] R_MDR  = 4'd12;
    localparam logic [3:0] R_IR   = 4'd14;
    localparam logic [3:0] R_DRAM = 4'd15;

    localparam logic [2:0] ALU_PASS     = 3'd0;
    localparam logic [2:0] ALU_ADD      = 3'd1;
    localparam logic [2:0] ALU_SUB      = 3'd2;
    localparam logic [2:0] ALU_INC      = 3'd3;
    localparam logic [2:0] ALU_PASS_IMM = 3'd4;

    logic [2:0]      state;
    logic [3:0]      op_q, dst_q, src_q;
    logic            z_q;
    logic [TO_W-1:0] cnt;
    logic [1:0]      err_q;

    logic [3:0] op_in, dst_in, src_in;
    logic       unused_imm;

    assign op_in      = bus.ir_in[DATA_W-1 -: 4];
    assign dst_in     = bus.ir_in[DATA_W-5 -: 4];
    assign src_in     = bus.ir_in[DATA_W-9 -: 4];
    assign unused_imm = ^bus.ir_in[DATA_W-13:0];

    function automatic logic is_illegal(input logic [3:0] op, input logic [3:0] dst,
                                        input logic [3:0] src);
        logic dst_bad;
        dst_bad = (dst == R_NONE) || (dst == R_IR) || (dst == R_DRAM);
        case (op)
            OP_MOV:                              is_illegal = (src == R_NONE) || dst_bad;
            OP_ADD, OP_SUB:                      is_illegal = (src == R_NONE);
            OP_INC:                              is_illegal = dst_bad;
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14:   is_illegal = 1'b1;
            default:                             is_illegal = 1'b0;
        endcase
    endfunction

    // Code 0 means "no register", so it maps to an all-zero enable vector.
    function automatic logic [15:0] onehot(input logic [3:0] code);
        onehot = (code == R_NONE) ? '0 : (16'd1 << code);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            dst_q <= '0;
            src_q <= '0;
            z_q   <= 1'b0;
            cnt   <= '0;
            err_q <= '0;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state <= S_FETCH;
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= op_in;
                    dst_q <= dst_in;
                    src_q <= src_in;
                    z_q   <= bus.alu_z;
                    cnt   <= '0;
                    if (is_illegal(op_in, dst_in, src_in)) begin
                        err_q[0] <= 1'b1;
                        state    <= S_HALT;
                    end else if (op_in == OP_HALT) begin
                        state <= S_HALT;
                    end else if (op_in == OP_LOAD || op_in == OP_STORE) begin
                        state <= S_MEM_WAIT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: state <= S_FETCH;
                S_MEM_WAIT: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (bus.dmem_ack) begin
                        state <= (op_q == OP_LOAD) ? S_MEM_CAP : S_FETCH;
                    end else if (cnt == TO_LAST) begin
                        err_q[1] <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_MEM_CAP: state <= S_FETCH;
                S_HALT:    state <= S_HALT;
                default:   state <= S_IDLE;
            endcase
        end
    end

    logic [3:0] rd_code, wr_code;

    always_comb begin
        rd_code      = R_NONE;
        wr_code      = R_NONE;
        bus.alu_op   = ALU_PASS;
        bus.ir_write = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.ac_reset = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        case (state)
            S_FETCH:  bus.ir_write = 1'b1;
            S_DECODE: bus.pc_inc   = 1'b1;
            S_EXEC: begin
                case (op_q)
                    OP_MOV: begin
                        rd_code = src_q;
                        wr_code = dst_q;
                    end
                    OP_ADD: begin
                        rd_code    = src_q;
                        wr_code    = R_AC;
                        bus.alu_op = ALU_ADD;
                    end
                    OP_SUB: begin
                        rd_code    = src_q;
                        wr_code    = R_AC;
                        bus.alu_op = ALU_SUB;
                    end
                    OP_INC: begin
                        rd_code    = dst_q;
                        wr_code    = dst_q;
                        bus.alu_op = ALU_INC;
                    end
                    OP_JZ: begin
                        if (z_q) begin
                            rd_code    = R_IR;
                            wr_code    = R_PC;
                            bus.alu_op = ALU_PASS_IMM;
                        end
                    end
                    OP_JMP: begin
                        rd_code    = R_IR;
                        wr_code    = R_PC;
                        bus.alu_op = ALU_PASS_IMM;
                    end
                    OP_CLRAC: bus.ac_reset = 1'b1;
                    default: ;
                endcase
            end
            S_MEM_WAIT: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (op_q == OP_STORE);
            end
            S_MEM_CAP: begin
                rd_code = R_DRAM;
                wr_code = R_MDR;
            end
            default: ;
        endcase
    end

    assign bus.bus_rd_en = onehot(rd_code);
    assign bus.bus_wr_en = onehot(wr_code);
    assign bus.busy      = (state != S_IDLE) && (state != S_HALT);
    assign bus.halted    = (state == S_HALT);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: vector table for single-cycle ops, hand sequences
// for memory wait, timeout, illegal decode and reset during a memory access.
module tb_bus_sequencer;
    logic clk;
    logic reset_n;

    bus_sequencer_if #(.DATA_W(24)) bus ();

    bus_sequencer #(
        .DATA_W     (24),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] ir;
        logic        z;
        logic [15:0] rd;
        logic [15:0] wr;
        logic [2:0]  op;
        logic        ac;
    } vec_t;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] wr;
        logic [2:0]  op;
        logic        ac;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no scoreboard entry expected one", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_rd"}, bus.bus_rd_en, e.rd);
            check({tag, "_wr"}, bus.bus_wr_en, e.wr);
            check({tag, "_alu"}, bus.alu_op, e.op);
            check({tag, "_acr"}, bus.ac_reset, e.ac);
        end
    endtask

    // At most one bus source and one sink must be active on every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot_rd", 32'($onehot0(bus.bus_rd_en)), 1);
            check("onehot_wr", 32'($onehot0(bus.bus_wr_en)), 1);
        end
    end

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.ir_in    = '0;
        bus.alu_z    = 1'b0;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic go();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("go_fetch", bus.ir_write, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        check({tag, "_fetch"}, bus.ir_write, 1);
        bus.ir_in = v.ir;
        bus.alu_z = v.z;
        e.rd = v.rd;
        e.wr = v.wr;
        e.op = v.op;
        e.ac = v.ac;
        sb.push_back(e);
        @(negedge clk);
        check({tag, "_pcinc"}, bus.pc_inc, 1);
        @(negedge clk);
        pop_check(tag);
        @(negedge clk);
    endtask

    vec_t        vecs[12];
    logic [23:0] ill_ir[7];
    logic [1:0]  ill_err[7];

    initial begin
        exp_t e;
        int   n;

        vecs[0]  = '{24'h000000, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0}; // NOP
        vecs[1]  = '{24'h12A000, 1'b0, 16'h0400, 16'h0004, 3'd0, 1'b0}; // MOV W<-AC
        vecs[2]  = '{24'h1BF000, 1'b0, 16'h8000, 16'h0800, 3'd0, 1'b0}; // MOV PC<-DRAM
        vecs[3]  = '{24'h205000, 1'b0, 16'h0020, 16'h0400, 3'd1, 1'b0}; // ADD X
        vecs[4]  = '{24'h30C000, 1'b0, 16'h1000, 16'h0400, 3'd2, 1'b0}; // SUB MDR
        vecs[5]  = '{24'h640000, 1'b0, 16'h0010, 16'h0010, 3'd3, 1'b0}; // INC Count
        vecs[6]  = '{24'h70005A, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0}; // JZ not taken
        vecs[7]  = '{24'h70005A, 1'b1, 16'h4000, 16'h0800, 3'd4, 1'b0}; // JZ taken
        vecs[8]  = '{24'h800123, 1'b0, 16'h4000, 16'h0800, 3'd4, 1'b0}; // JMP
        vecs[9]  = '{24'h900000, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1}; // CLRAC
        vecs[10] = '{24'h11E000, 1'b0, 16'h4000, 16'h0002, 3'd0, 1'b0}; // MOV H<-IR
        vecs[11] = '{24'h6D0000, 1'b1, 16'h2000, 16'h2000, 3'd3, 1'b0}; // INC MAR

        ill_ir[0] = 24'h1E1000; ill_err[0] = 2'b01; // MOV into IR
        ill_ir[1] = 24'h102000; ill_err[1] = 2'b01; // MOV dst none
        ill_ir[2] = 24'h150000; ill_err[2] = 2'b01; // MOV src none
        ill_ir[3] = 24'h300000; ill_err[3] = 2'b01; // SUB src none
        ill_ir[4] = 24'h6F0000; ill_err[4] = 2'b01; // INC DRAM
        ill_ir[5] = 24'hA00000; ill_err[5] = 2'b01; // undefined op
        ill_ir[6] = 24'hF00000; ill_err[6] = 2'b00; // HALT is legal

        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        mon_en = 1'b1;
        check("rst_rd", bus.bus_rd_en, 0);
        check("rst_wr", bus.bus_wr_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_err", bus.err, 0);
        check("rst_req", bus.dmem_req, 0);
        do_reset();
        check("idle_irw", bus.ir_write, 0);
        check("idle_busy", bus.busy, 0);

        go();
        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        check("table_err", bus.err, 0);
        check("table_busy", bus.busy, 1);

        // LOAD with ack on the second wait cycle
        check("load_fetch", bus.ir_write, 1);
        bus.ir_in = 24'h400000;
        e.rd = 16'h8000; e.wr = 16'h1000; e.op = 3'd0; e.ac = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        check("load_pcinc", bus.pc_inc, 1);
        @(negedge clk);
        n = 0;
        while (bus.dmem_req === 1'b1 && n < 40) begin
            n++;
            check("load_we", bus.dmem_we, 0);
            bus.dmem_ack = (n == 2);
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        check("load_req_cycles", n, 2);
        pop_check("load_cap");
        @(negedge clk);
        check("load_next_fetch", bus.ir_write, 1);

        // STORE with immediate ack
        bus.ir_in = 24'h500000;
        @(negedge clk);
        @(negedge clk);
        check("st_req", bus.dmem_req, 1);
        check("st_we", bus.dmem_we, 1);
        check("st_rd", bus.bus_rd_en, 0);
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        check("st_req_drop", bus.dmem_req, 0);
        check("st_next_fetch", bus.ir_write, 1);

        // STORE with no ack runs into the timeout
        bus.ir_in = 24'h500000;
        @(negedge clk);
        @(negedge clk);
        n = 0;
        while (bus.dmem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", n, 16);
        check("to_err", bus.err, 2'b10);
        check("to_halted", bus.halted, 1);
        check("to_busy", bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("to_start_ignored", bus.halted, 1);
        check("to_no_fetch", bus.ir_write, 0);

        // illegal decodes and HALT
        for (int i = 0; i < 7; i++) begin
            do_reset();
            go();
            bus.ir_in = ill_ir[i];
            @(negedge clk);
            @(negedge clk);
            check($sformatf("ill%0d_err", i), bus.err, ill_err[i]);
            check($sformatf("ill%0d_halted", i), bus.halted, 1);
            check($sformatf("ill%0d_rd", i), bus.bus_rd_en, 0);
            check($sformatf("ill%0d_wr", i), bus.bus_wr_en, 0);
            if (i == 0) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                @(negedge clk);
                check("ill_start_ignored", bus.halted, 1);
                check("ill_no_fetch", bus.ir_write, 0);
            end
        end

        // reset asserted in the middle of a memory wait
        do_reset();
        go();
        bus.ir_in = 24'h400000;
        @(negedge clk);
        @(negedge clk);
        check("mw_req", bus.dmem_req, 1);
        check("mw_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        check("mw_rst_req", bus.dmem_req, 0);
        check("mw_rst_busy", bus.busy, 0);
        check("mw_rst_err", bus.err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mw_idle_busy", bus.busy, 0);
        check("mw_idle_halted", bus.halted, 0);
        check("mw_idle_irw", bus.ir_write, 0);
        go();
        @(negedge clk);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end
endmodule
